// File: rtl/crypt_ctrl_pkg.sv
// Shared types and constants for the encrypt/decrypt configuration control path.
//   cmd_t        : host command encoding carried on host_cmd
//   seq_state_t  : states of the configuration sequencer FSM
//   MODE_BIT     : bit of the configuration word that selects run (1) or config (0) mode
//   BEATS        : host beats per configuration word at the default widths
package crypt_ctrl_pkg;

    localparam int DEF_HOST_W = 16;
    localparam int DEF_CFG_W  = 64;
    localparam int MODE_BIT   = 0;
    localparam int BEATS      = DEF_CFG_W / DEF_HOST_W;

    typedef enum logic [1:0] {
        CMD_LOAD   = 2'b00,
        CMD_COMMIT = 2'b01,
        CMD_RUN    = 2'b10,
        CMD_STOP   = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WRITE  = 2'b01,
        ST_VERIFY = 2'b10,
        ST_DRAIN  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/cfg_shadow_assembler.sv
// Collects HOST_W-bit host beats into a CFG_W-bit shadow word, lowest beat first.
// Ports:
//   clk, rst  : clock and asynchronous active-low reset
//   load      : write data into the next free beat slot and advance the count
//   clear     : restart the beat count (shadow contents are kept until overwritten)
//   data      : beat payload
//   shadow    : assembled configuration word
//   full      : all beat slots have been written since the last clear
module cfg_shadow_assembler
    import crypt_ctrl_pkg::*;
#(
    parameter int HOST_W = DEF_HOST_W,
    parameter int CFG_W  = DEF_CFG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [HOST_W-1:0] data,
    output logic [CFG_W-1:0]  shadow,
    output logic              full
);

    localparam int NB = CFG_W / HOST_W;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] NB_C  = CW'(NB);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CFG_W-1:0] shadow_r;
    logic [CW-1:0]    cnt_r;
    logic             full_s;

    // Full flag decoded from the beat count.
    always_comb begin
        full_s = 1'b0;
        if (cnt_r == NB_C) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
    end

    // Shadow storage and beat counter; clear wins over a simultaneous load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= {CFG_W{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (load && !full_s) begin
            for (int k = 0; k < NB; k++) begin
                if (int'(cnt_r) == k) begin
                    shadow_r[k*HOST_W +: HOST_W] <= data;
                end
            end
            cnt_r <= cnt_r + ONE_C;
        end
    end

    assign shadow = shadow_r;
    assign full   = full_s;

endmodule

// File: rtl/config_sequencer.sv
// Host-facing owner of the crypto unit's configuration register. Assembles a
// configuration word from host beats, commits it, switches between config and
// run mode, and read-back verifies every write it issues.
// Ports:
//   clk, rst           : clock and asynchronous active-low reset
//   host_valid/ready   : command handshake (ready only while idle)
//   host_cmd/host_data : command (LOAD/COMMIT/RUN/STOP) and LOAD payload
//   cfg_wen/cfg_data   : one-cycle write to config_register
//   cfg_q              : current config_register value
//   core_busy          : crypto core still has an operation in flight
//   done               : one-cycle completion pulse
//   err                : sticky error, cleared by the next accepted command
//   locked             : run-mode bit of config_register
module config_sequencer
    import crypt_ctrl_pkg::*;
#(
    parameter int HOST_W    = DEF_HOST_W,
    parameter int CFG_W     = DEF_CFG_W,
    parameter int DRAIN_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_cmd,
    input  logic [HOST_W-1:0] host_data,
    output logic              cfg_wen,
    output logic [CFG_W-1:0]  cfg_data,
    input  logic [CFG_W-1:0]  cfg_q,
    input  logic              core_busy,
    output logic              done,
    output logic              err,
    output logic              locked
);

    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam logic [DW-1:0] DRAIN_LOAD_C = DW'(DRAIN_MAX);
    localparam logic [DW-1:0] ONE_C        = DW'(1);

    seq_state_t       state_r;
    logic [DW-1:0]    drain_cnt_r;
    logic             ready_r;
    logic             cfg_wen_r;
    logic [CFG_W-1:0] cfg_data_r;
    logic             done_r;
    logic             err_r;

    logic             accept_s;
    cmd_t             cmd_s;
    logic             locked_s;
    logic             load_s;
    logic             clear_s;
    logic [CFG_W-1:0] shadow_s;
    logic             full_s;
    logic [CFG_W-1:0] commit_word_s;
    logic [CFG_W-1:0] run_word_s;
    logic [CFG_W-1:0] stop_word_s;

    cfg_shadow_assembler #(
        .HOST_W (HOST_W),
        .CFG_W  (CFG_W)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .clear  (clear_s),
        .data   (host_data),
        .shadow (shadow_s),
        .full   (full_s)
    );

    // Handshake decode and candidate write words. The mode bit is forced on
    // every word so a commit can never sneak the unit into run mode.
    always_comb begin
        accept_s      = host_valid & ready_r;
        cmd_s         = cmd_t'(host_cmd);
        locked_s      = cfg_q[MODE_BIT];
        commit_word_s = shadow_s;
        commit_word_s[MODE_BIT] = 1'b0;
        run_word_s    = cfg_q;
        run_word_s[MODE_BIT] = 1'b1;
        stop_word_s   = cfg_q;
        stop_word_s[MODE_BIT] = 1'b0;
    end

    // Shadow control: LOAD only lands when unlocked with a free slot; every
    // accepted COMMIT restarts the beat count whether or not it succeeds.
    always_comb begin
        load_s  = 1'b0;
        clear_s = 1'b0;
        if (accept_s) begin
            case (cmd_s)
                CMD_LOAD:   load_s  = !locked_s && !full_s;
                CMD_COMMIT: clear_s = 1'b1;
                default: begin
                    load_s  = 1'b0;
                    clear_s = 1'b0;
                end
            endcase
        end else begin
            load_s  = 1'b0;
            clear_s = 1'b0;
        end
    end

    // Sequencer FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= {DW{1'b0}};
            ready_r     <= 1'b1;
            cfg_wen_r   <= 1'b0;
            cfg_data_r  <= {CFG_W{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            cfg_wen_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        err_r <= 1'b0;
                        case (cmd_s)
                            CMD_LOAD: begin
                                if (locked_s || full_s) begin
                                    err_r <= 1'b1;
                                end
                            end
                            CMD_COMMIT: begin
                                if (full_s && !locked_s) begin
                                    cfg_data_r <= commit_word_s;
                                    cfg_wen_r  <= 1'b1;
                                    ready_r    <= 1'b0;
                                    state_r    <= ST_WRITE;
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            CMD_RUN: begin
                                if (!locked_s) begin
                                    cfg_data_r <= run_word_s;
                                    cfg_wen_r  <= 1'b1;
                                    ready_r    <= 1'b0;
                                    state_r    <= ST_WRITE;
                                end else begin
                                    err_r <= 1'b1;
                                end
                            end
                            CMD_STOP: begin
                                if (locked_s) begin
                                    drain_cnt_r <= DRAIN_LOAD_C;
                                    ready_r     <= 1'b0;
                                    state_r     <= ST_DRAIN;
                                end else begin
                                    done_r <= 1'b1;
                                end
                            end
                            default: err_r <= 1'b1;
                        endcase
                    end
                end
                ST_WRITE: begin
                    // cfg_wen was high for this one cycle; register captures now.
                    state_r <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (cfg_q == cfg_data_r) begin
                        done_r <= 1'b1;
                    end else begin
                        err_r <= 1'b1;
                    end
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (!core_busy) begin
                        cfg_data_r <= stop_word_s;
                        cfg_wen_r  <= 1'b1;
                        state_r    <= ST_WRITE;
                    end else if (drain_cnt_r <= ONE_C) begin
                        // Core never drained: give up and leave the unit locked.
                        err_r   <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - ONE_C;
                    end
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_ready = ready_r;
    assign cfg_wen    = cfg_wen_r;
    assign cfg_data   = cfg_data_r;
    assign done       = done_r;
    assign err        = err_r;
    assign locked     = locked_s;

endmodule
